seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller that shares one seg decoder (i_signbit/seg_in -> seg_out) across NUM_CH digits.
//  Each channel holds a 4-bit two's-complement ALU result (-8..7) and is shown as sign + magnitude.
//  Per slot the block drives the decoder inputs, a minus indicator and one active-low digit enable.
//  A blanking gap before each slot suppresses ghosting. New values arrive by valid/ready and are applied only at frame boundaries (no tearing).
// PARAMETERS
//  NUM_CH     4      number of digits/channels (>=1)
//  SCAN_DIV   50000  clk cycles a digit is lit per slot (>=1)
//  BLANK_CYC  500    clk cycles all digits are off before each slot (>=1)
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  disp_en      in   1           1 = scan; 0 = all digits off, FSM idle
//  upd_valid    in   1           update request
//  upd_ready    out  1           1 = no update pending, can accept
//  upd_data     in   4*NUM_CH    channel k value = upd_data[4k+3:4k], two's complement
//  dec_signbit  out  1           to decoder i_signbit (1 = negative)
//  dec_mag      out  4           to decoder seg_in, magnitude 0..8
//  minus_n      out  1           active-low minus indicator for the lit digit
//  an_n         out  NUM_CH      active-low one-hot digit enable
//  frame_start  out  1           1-cycle pulse on entry to BLANK of slot 0
// BEHAVIOUR
//  Reset (async assert, sync release). State=IDLE, idx=0, an_n=all 1, minus_n=1, dec_signbit=0, dec_mag=0.
//    Also: frame_start=0, active regs=0, shadow=0, pending=0 (upd_ready=1).
//  All outputs are registered; upd_ready = ~pending.
//  FSM IDLE:
//    disp_en=1 -> BLANK with idx=0 next cycle (frame_start=1 that cycle). Outputs stay off while in IDLE.
//  FSM BLANK:
//    an_n = all 1 for exactly BLANK_CYC cycles, then -> SHOW.
//    dec_signbit, dec_mag and minus_n are loaded for channel idx on entry to BLANK and held through SHOW.
//  FSM SHOW:
//    an_n[idx]=0, others 1, for exactly SCAN_DIV cycles.
//    Then idx = (idx==NUM_CH-1) ? 0 : idx+1, and -> BLANK.
//  Frame = NUM_CH*(BLANK_CYC+SCAN_DIV) cycles. idx wraps NUM_CH-1 -> 0; that wrap is the frame boundary.
//  disp_en=0 in any state:
//    next cycle -> IDLE, an_n=all 1, minus_n=1, idx=0, counters cleared.
//    Re-enable always restarts at slot 0.
//  Decode for v = active[idx]:
//    dec_signbit = v[3].
//    dec_mag = v[3] ? (~v+1) mod 16 : v. So -8 (4'h8) -> mag 8, sign 1; 0 -> mag 0, sign 0.
//    minus_n = ~v[3].
//  Update handshake:
//    Accept when upd_valid & upd_ready: shadow <= upd_data, pending <= 1.
//    upd_data is don't-care when not accepted. While pending, upd_ready=0 and the requester stalls.
//  Apply rules:
//    Frame boundary (SHOW end with idx==NUM_CH-1) with pending=1: active <= shadow, pending <= 0.
//      The new values are used from slot 0 onward.
//    In IDLE with pending=1: applied the next cycle.
//    Accept in the same cycle as a boundary: pending was 0, so nothing is applied; the data waits for the next boundary.
//  Reset mid-operation: immediately forces the reset values and discards any pending update.
// TESTING  (NUM_CH=2, SCAN_DIV=4, BLANK_CYC=2)
//  1. Reset with disp_en=1 -> an_n=2'b11, minus_n=1, dec_mag=0, upd_ready=1.
//     After release: frame_start pulse, 2 blank cycles, an_n=2'b10 for 4 cycles, dec_mag=0.
//  2. Idle load upd_data=8'h5D, then enable:
//     slot0: dec_signbit=1, dec_mag=3, minus_n=0, an_n=10 (4 cycles);
//     slot1: dec_signbit=0, dec_mag=5, minus_n=1, an_n=01; frame period 12 cycles.
//  3. upd_data=8'h08 -> ch0: dec_signbit=1, dec_mag=8; ch1: 0, dec_signbit=0, minus_n=1.
//  4. Mid-frame update 8'h21:
//     upd_ready=0 next cycle; displayed values unchanged until wrap.
//     Slot0 after next frame_start shows mag 1; second upd_valid stalls until then.
//  5. disp_en low in slot1 SHOW -> next cycle an_n=11, IDLE.
//     Re-enable -> frame_start, restarts at slot0 after 2 blank cycles.
//  6. rst_n low mid-SHOW with an update pending -> same cycle an_n=11.
//     After release: active=0, upd_ready=1, pending update lost.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_if
// Brief    : Update handshake bundle (valid/ready plus packed channel values)
//            between a value producer and seg_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic                  upd_valid;
    logic                  upd_ready;
    logic [4*NUM_CH-1:0]   upd_data;

    modport master (output upd_valid, output upd_data, input upd_ready);
    modport slave  (input upd_valid, input upd_data, output upd_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed sign/magnitude digit scanner sharing one segment
//            decoder across NUM_CH digits, with frame-synchronous value update.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              disp_en,
    seg_scan_ctrl_if.slave         upd,
    output logic                   dec_signbit,
    output logic [3:0]             dec_mag,
    output logic                   minus_n,
    output logic [NUM_CH-1:0]      an_n,
    output logic                   frame_start
);

    localparam int c_CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SHOW_LAST  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_CH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [NUM_CH-1:0]  c_AN_ONE     = NUM_CH'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BLANK = 2'd1;
    localparam logic [1:0] c_ST_SHOW  = 2'd2;

    logic [1:0]            r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [c_IDX_W-1:0]    r_idx,     w_idx_nxt;
    logic [NUM_CH-1:0]     r_an_n,    w_an_nxt;
    logic                  r_minus_n, w_minus_nxt;
    logic                  r_signbit, w_sign_nxt;
    logic [3:0]            r_mag,     w_mag_nxt;
    logic                  r_fs,      w_fs_nxt;
    logic [4*NUM_CH-1:0]   r_active,  w_active_nxt;
    logic [4*NUM_CH-1:0]   r_shadow,  w_shadow_nxt;
    logic                  r_pending, w_pending_nxt;

    logic                  w_show_end;
    logic                  w_boundary;
    logic                  w_accept;
    logic                  w_apply;
    logic [c_IDX_W-1:0]    w_idx_inc;
    logic [c_IDX_W-1:0]    w_sel_idx;
    logic [3:0]            w_ch_val [NUM_CH];
    logic [3:0]            w_sel_val;
    logic                  w_sel_sign;
    logic [3:0]            w_sel_mag;

    assign w_show_end = (r_state == c_ST_SHOW) && (r_cnt == c_SHOW_LAST);
    assign w_boundary = disp_en && w_show_end && (r_idx == c_IDX_LAST);
    assign w_accept   = upd.upd_valid && !r_pending;
    assign w_apply    = r_pending && (w_boundary || (r_state == c_ST_IDLE));
    assign w_idx_inc  = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;

    // Accept and apply are mutually exclusive: one needs pending clear, the other set.
    always_comb begin : p_data_next
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        if (w_apply) begin
            w_active_nxt  = r_shadow;
            w_pending_nxt = 1'b0;
        end
        if (w_accept) begin
            w_shadow_nxt  = upd.upd_data;
            w_pending_nxt = 1'b1;
        end
    end

    // Decoder values come from the post-apply set so slot 0 of a new frame shows new data.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch_val
        assign w_ch_val[k] = w_active_nxt[4*k +: 4];
    end

    assign w_sel_idx  = (r_state == c_ST_SHOW) ? w_idx_inc : '0;
    assign w_sel_val  = w_ch_val[w_sel_idx];
    assign w_sel_sign = w_sel_val[3];
    assign w_sel_mag  = w_sel_val[3] ? (~w_sel_val + 4'd1) : w_sel_val;

    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_an_nxt    = r_an_n;
        w_minus_nxt = r_minus_n;
        w_sign_nxt  = r_signbit;
        w_mag_nxt   = r_mag;
        w_fs_nxt    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_an_nxt    = '1;
                w_minus_nxt = 1'b1;
                w_sign_nxt  = 1'b0;
                w_mag_nxt   = 4'd0;
                if (disp_en) begin
                    w_state_nxt = c_ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_fs_nxt    = 1'b1;
                    w_sign_nxt  = w_sel_sign;
                    w_mag_nxt   = w_sel_mag;
                    w_minus_nxt = ~w_sel_sign;
                end
            end
            c_ST_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_nxt = c_ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_an_nxt    = ~(c_AN_ONE << r_idx);
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_SHOW: begin
                if (w_show_end) begin
                    w_state_nxt = c_ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_an_nxt    = '1;
                    w_idx_nxt   = w_idx_inc;
                    w_fs_nxt    = (w_idx_inc == '0);
                    w_sign_nxt  = w_sel_sign;
                    w_mag_nxt   = w_sel_mag;
                    w_minus_nxt = ~w_sel_sign;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (!disp_en) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_an_nxt    = '1;
            w_minus_nxt = 1'b1;
            w_sign_nxt  = 1'b0;
            w_mag_nxt   = 4'd0;
            w_fs_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_an_n    <= '1;
            r_minus_n <= 1'b1;
            r_signbit <= 1'b0;
            r_mag     <= 4'd0;
            r_fs      <= 1'b0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_an_n    <= w_an_nxt;
            r_minus_n <= w_minus_nxt;
            r_signbit <= w_sign_nxt;
            r_mag     <= w_mag_nxt;
            r_fs      <= w_fs_nxt;
            r_active  <= w_active_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign upd.upd_ready = ~r_pending;
    assign dec_signbit   = r_signbit;
    assign dec_mag       = r_mag;
    assign minus_n       = r_minus_n;
    assign an_n          = r_an_n;
    assign frame_start   = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl (2 channels, short timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int NUM_CH    = 2;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_en;
    logic              dec_signbit;
    logic [3:0]        dec_mag;
    logic              minus_n;
    logic [NUM_CH-1:0] an_n;
    logic              frame_start;

    seg_scan_ctrl_if #(.NUM_CH(NUM_CH)) upd_if ();

    seg_scan_ctrl #(
        .NUM_CH    (NUM_CH),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_en     (disp_en),
        .upd         (upd_if),
        .dec_signbit (dec_signbit),
        .dec_mag     (dec_mag),
        .minus_n     (minus_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] an;
        logic       sg;
        logic [3:0] mag;
        logic       mn;
    } slot_t;

    typedef struct {
        logic [7:0] data;
        slot_t      s0;
        slot_t      s1;
    } vec_t;

    slot_t sb_q[$];
    slot_t mon_e;
    vec_t  vecs [5];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic [1:0] an_prev = 2'b11;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push2(input slot_t a, input slot_t b);
        sb_q.push_back(a);
        sb_q.push_back(b);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk(nm, sb_q.size(), 0);
    endtask

    task automatic wait_an(input logic [1:0] v, input string nm);
        int n = 0;
        while (an_n !== v && n < 100) begin
            cyc(1);
            n++;
        end
        chk(nm, an_n, v);
    endtask

    task automatic idle_load(input logic [7:0] d);
        int n = 0;
        while (upd_if.upd_ready !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("load_ready", upd_if.upd_ready, 1);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = d;
        cyc(1);
        chk("load_pending", upd_if.upd_ready, 0);
        upd_if.upd_valid = 1'b0;
        cyc(1);
        chk("idle_apply", upd_if.upd_ready, 1);
    endtask

    task automatic frame_period();
        int n = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("fs_seen", frame_start, 1);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        chk("frame_period", n, 12);
    endtask

    // Each entry into a lit slot is compared against the next expected slot.
    always @(negedge clk) begin
        if (an_n !== 2'b11 && an_prev === 2'b11 && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("slot_an",    an_n,        mon_e.an);
            chk("slot_sign",  dec_signbit, mon_e.sg);
            chk("slot_mag",   dec_mag,     mon_e.mag);
            chk("slot_minus", minus_n,     mon_e.mn);
        end
        an_prev = an_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int n;
        slot_t z0, z1;
        z0 = '{2'b10, 1'b0, 4'd0, 1'b1};
        z1 = '{2'b01, 1'b0, 4'd0, 1'b1};

        vecs[0] = '{8'h5D, '{2'b10, 1'b1, 4'd3, 1'b0}, '{2'b01, 1'b0, 4'd5, 1'b1}};
        vecs[1] = '{8'h08, '{2'b10, 1'b1, 4'd8, 1'b0}, '{2'b01, 1'b0, 4'd0, 1'b1}};
        vecs[2] = '{8'h7F, '{2'b10, 1'b1, 4'd1, 1'b0}, '{2'b01, 1'b0, 4'd7, 1'b1}};
        vecs[3] = '{8'h89, '{2'b10, 1'b1, 4'd7, 1'b0}, '{2'b01, 1'b1, 4'd8, 1'b0}};
        vecs[4] = '{8'h60, '{2'b10, 1'b0, 4'd0, 1'b1}, '{2'b01, 1'b0, 4'd6, 1'b1}};

        // Reset with display enabled
        rst_n = 1'b0;
        disp_en = 1'b1;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_data  = 8'h00;
        cyc(3);
        chk("rst_an",     an_n, 2'b11);
        chk("rst_minus",  minus_n, 1);
        chk("rst_mag",    dec_mag, 0);
        chk("rst_sign",   dec_signbit, 0);
        chk("rst_fs",     frame_start, 0);
        chk("rst_ready",  upd_if.upd_ready, 1);
        push2(z0, z1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_fs",     frame_start, 1);
        chk("first_blank",  an_n, 2'b11);
        cyc(1);
        chk("fs_pulse_end", frame_start, 0);
        chk("blank2",       an_n, 2'b11);
        cyc(1);
        chk("show_entry",   an_n, 2'b10);
        n = 0;
        while (an_n === 2'b10 && n < 20) begin
            n++;
            cyc(1);
        end
        chk("show_len", n, 4);
        n = 0;
        while (an_n === 2'b11 && n < 20) begin
            n++;
            cyc(1);
        end
        chk("blank_len", n, 2);
        drain("t1_drain");

        // Idle load, then enable and time a frame
        disp_en = 1'b0;
        cyc(2);
        chk("idle_off", an_n, 2'b11);
        idle_load(8'h5D);
        push2(vecs[0].s0, vecs[0].s1);
        push2(vecs[0].s0, vecs[0].s1);
        disp_en = 1'b1;
        frame_period();
        drain("t2_drain");

        // Table of values, each loaded while idle and shown for two frames
        for (int i = 0; i < 5; i++) begin
            disp_en = 1'b0;
            cyc(2);
            idle_load(vecs[i].data);
            push2(vecs[i].s0, vecs[i].s1);
            push2(vecs[i].s0, vecs[i].s1);
            disp_en = 1'b1;
            drain("tbl_drain");
        end

        // Mid-frame update waits for the frame boundary
        disp_en = 1'b0;
        cyc(2);
        idle_load(8'h5D);
        disp_en = 1'b1;
        wait_an(2'b10, "t4_slot0");
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h21;
        cyc(1);
        chk("t4_pending", upd_if.upd_ready, 0);
        sb_q.push_back(vecs[0].s1);
        push2('{2'b10, 1'b0, 4'd1, 1'b1}, '{2'b01, 1'b0, 4'd2, 1'b1});
        upd_if.upd_data = 8'h34;
        n = 0;
        while (upd_if.upd_ready !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        chk("t4_ready_at_fs", frame_start, 1);
        chk("t4_stalled", (n > 4), 1);
        cyc(1);
        chk("t4_accept2", upd_if.upd_ready, 0);
        upd_if.upd_valid = 1'b0;
        push2('{2'b10, 1'b0, 4'd4, 1'b1}, '{2'b01, 1'b0, 4'd3, 1'b1});
        drain("t4_drain");

        // Disable during slot 1, re-enable restarts at slot 0
        wait_an(2'b01, "t5_slot1");
        disp_en = 1'b0;
        cyc(1);
        chk("t5_off",   an_n, 2'b11);
        chk("t5_minus", minus_n, 1);
        cyc(1);
        chk("t5_idle",  an_n, 2'b11);
        sb_q.push_back('{2'b10, 1'b0, 4'd4, 1'b1});
        disp_en = 1'b1;
        cyc(1);
        chk("t5_fs",     frame_start, 1);
        chk("t5_blank1", an_n, 2'b11);
        cyc(1);
        chk("t5_blank2", an_n, 2'b11);
        cyc(1);
        chk("t5_slot0",  an_n, 2'b10);
        drain("t5_drain");

        // Asynchronous reset with an update pending
        wait_an(2'b10, "t6_slot0");
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h77;
        cyc(1);
        upd_if.upd_valid = 1'b0;
        chk("t6_pending", upd_if.upd_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_an",    an_n, 2'b11);
        chk("t6_async_minus", minus_n, 1);
        chk("t6_async_mag",   dec_mag, 0);
        chk("t6_async_ready", upd_if.upd_ready, 1);
        push2(z0, z1);
        push2(z0, z1);
        @(negedge clk);
        rst_n = 1'b1;
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
